ram_seq_writer: RTL

Sequential writer for the team's small synchronous RAMs: accepts a stream of data words over a valid/ready handshake and writes them to consecutive RAM addresses from a programmable base address. It is the producer/writer side of the address/data interface that the ROM/RAM readers consume. It fills or preloads a memory that is later read back by the address-sweeping readers. Write-port outputs are registered and connect directly to a RAM write port.

---
 rtl/ram_seq_writer.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_seq_writer.sv
// Streams handshaked words into consecutive RAM addresses starting at a latched base.
// The write port is registered with one cycle of latency after each accepted beat.
module ram_seq_writer #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [CW-1:0]         r_len, w_len_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_busy, r_done;
  logic                  w_ready;
  logic [CW-1:0]         w_len_clamped;
  logic [CW-1:0]         w_count_inc;

  assign w_ready       = (r_state == S_WRITE) && !abort;
  assign w_len_clamped = (length > CW'(DEPTH)) ? CW'(DEPTH) : length;
  assign w_count_inc   = r_count + CW'(1);

  // State register and registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_len   <= w_len_nxt;
      r_count <= w_count_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state and next write-port values
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_len_nxt   = r_len;
    w_count_nxt = r_count;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_base_nxt  = base_addr;
          w_len_nxt   = w_len_clamped;
          w_count_nxt = '0;
          w_state_nxt = (w_len_clamped == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (in_valid) begin
          w_we_nxt    = 1'b1;
          // Address wraps modulo DEPTH by truncation
          w_addr_nxt  = r_base + r_count[ADDR_WIDTH-1:0];
          w_wdata_nxt = in_data;
          w_count_nxt = w_count_inc;
          if (w_count_inc == r_len) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = w_ready;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;

endmodule
